// File: rtl/divider_thirtytwo_bit_seq_if.sv
// divider_thirtytwo_bit_seq_if: start/busy/done handshake and operand/result bus of the divider
interface divider_thirtytwo_bit_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_thirtytwo_bit_seq.sv
// divider_thirtytwo_bit_seq: iterative restoring divider, one quotient bit per cycle, DIV/DIVU semantics
module divider_thirtytwo_bit_seq #(
   parameter int WIDTH = 32
) (
   input logic                      clk,
   input logic                      reset,
   divider_thirtytwo_bit_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quo_out_q, quo_out_d, rem_out_q, rem_out_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] shifted, diff;
   logic             borrow, ge, sign_a, sign_b;
   assign bus.busy        = (state_q == RUN) || (state_q == FIX);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quo_out_q;
   assign bus.remainder   = rem_out_q;
   assign bus.div_by_zero = dbz_q;
   // Next state and datapath: accept, shift-subtract iterations, then sign fix-up into the held outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      quo_out_d = quo_out_q;
      rem_out_d = rem_out_q;
      dbz_d     = dbz_q;
      sign_a    = bus.is_signed & bus.dividend[WIDTH-1];
      sign_b    = bus.is_signed & bus.divisor[WIDTH-1];
      shifted   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      {borrow, diff} = {1'b0, shifted} - {1'b0, dvs_q};
      ge        = rem_q[WIDTH-1] | ~borrow;
      case (state_q)
         IDLE, DONE: begin
            state_d = bus.start ? RUN : IDLE;
            if (bus.start) begin
               quo_d     = sign_a ? -bus.dividend : bus.dividend;
               dvs_d     = sign_b ? -bus.divisor : bus.divisor;
               rem_d     = '0;
               cnt_d     = CW'(WIDTH);
               neg_quo_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
            end
         end
         RUN: begin
            rem_d   = ge ? diff : shifted;
            quo_d   = {quo_q[WIDTH-2:0], ge};
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? FIX : RUN;
         end
         default: begin
            dbz_d     = (dvs_q == '0);
            quo_out_d = (dvs_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
            rem_out_d = neg_rem_q ? -rem_q : rem_q;
            state_d   = DONE;
         end
      endcase
   end
   // State and datapath registers, cleared asynchronously so a reset aborts any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         quo_out_q <= quo_out_d;
         rem_out_q <= rem_out_d;
         dbz_q     <= dbz_d;
      end
   end
endmodule
